// File: rtl/fifo_pkt_ctrl_if.sv
// Signal bundle between the packet controller, its sample FIFO and the framer stream.
// master = controller side, slave = FIFO/framer/environment side.
interface fifo_pkt_ctrl_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  enable;
    logic                  fifo_we;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_re;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [47:0]           pkt_count;
    logic [31:0]           drop_count;
    logic                  busy;

    modport master (
        input  enable, fifo_we, fifo_full, fifo_empty, fifo_dout, m_tready,
        output fifo_re, m_tdata, m_tvalid, m_tlast, pkt_count, drop_count, busy
    );

    modport slave (
        output enable, fifo_we, fifo_full, fifo_empty, fifo_dout, m_tready,
        input  fifo_re, m_tdata, m_tvalid, m_tlast, pkt_count, drop_count, busy
    );
endinterface

// File: rtl/fifo_pkt_ctrl.sv
// Read-side packet controller: drains PKT_WORDS buffered samples behind a sequence-numbered
// header into a valid/ready stream, tracking FIFO occupancy and counting dropped writes.
module fifo_pkt_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int PKT_WORDS  = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_pkt_ctrl_if.master bus
);
    localparam int          OW      = $clog2(DEPTH) + 1;
    localparam int          RW      = $clog2(PKT_WORDS + 1);
    localparam logic [15:0] HDR_TAG = 16'h6E58;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;

    state_t                state_q, state_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [RW-1:0]         rem_q, rem_d;
    ent_t [1:0]            q_q, q_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  fly_q, fly_last_q;
    logic [47:0]           pkt_q;
    logic [31:0]           drop_q;

    ent_t                  head, in_ent;
    logic                  tvalid, pop, credit, push, hdr_push, re, re_last;
    logic [2:0]            fill;
    logic [DATA_WIDTH-1:0] hdr;

    // The word returning from the FIFO counts as queued in its arrival cycle, so an
    // empty queue bypasses it straight to the output.
    always_comb begin
        head.data = bus.fifo_dout;
        head.last = fly_last_q;
        if (cnt_q != 2'd0) head = q_q[0];
        tvalid = (cnt_q != 2'd0) || fly_q;
        pop    = tvalid && bus.m_tready;
        fill   = 3'(cnt_q) + 3'(fly_q) - 3'(pop);
        credit = fill < 3'd2;
        hdr          = '0;
        hdr[63:48]   = HDR_TAG;
        hdr[47:0]    = pkt_q;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        re       = 1'b0;
        re_last  = 1'b0;
        hdr_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && occ_q >= OW'(PKT_WORDS)) state_d = HEADER;
            end
            HEADER: begin
                // Wait for the previous packet's tlast beat to leave so pkt_count is current.
                if (credit && cnt_q == 2'd0 && !fly_q) begin
                    hdr_push = 1'b1;
                    rem_d    = RW'(PKT_WORDS);
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (credit) begin
                    re      = 1'b1;
                    re_last = (rem_q == RW'(1));
                    rem_d   = rem_q - RW'(1);
                    if (re_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        push   = hdr_push || fly_q;
        in_ent.data = hdr_push ? hdr : bus.fifo_dout;
        in_ent.last = hdr_push ? 1'b0 : fly_last_q;
        if (pop) begin
            if (cnt_q != 2'd0) begin
                q_d[0] = q_q[1];
                cnt_d  = cnt_q - 2'd1;
            end else begin
                push = 1'b0;
            end
        end
        if (push) begin
            q_d[cnt_d[0]] = in_ent;
            cnt_d         = cnt_d + 2'd1;
        end
        occ_d = occ_q;
        if ((bus.fifo_we && !bus.fifo_full) && !(re && !bus.fifo_empty)) occ_d = occ_q + OW'(1);
        if (!(bus.fifo_we && !bus.fifo_full) && (re && !bus.fifo_empty)) occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            fly_q      <= 1'b0;
            fly_last_q <= 1'b0;
            pkt_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            fly_q      <= re;
            fly_last_q <= re_last;
            if (pop && head.last) pkt_q <= pkt_q + 48'd1;
            if (bus.fifo_we && bus.fifo_full && drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
        end
    end

    assign bus.fifo_re    = re;
    assign bus.m_tdata    = head.data;
    assign bus.m_tlast    = head.last;
    assign bus.m_tvalid   = tvalid;
    assign bus.pkt_count  = pkt_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (state_q != IDLE) || (cnt_q != 2'd0) || fly_q;
endmodule

// File: tb/tb_fifo_pkt_ctrl.sv
// Bench for fifo_pkt_ctrl: behavioural FIFO model plus an expected-beat scoreboard.
module tb_fifo_pkt_ctrl;
    localparam int DW = 64, DEPTH = 16, PKT = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_pkt_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fifo_pkt_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_cmp = 0, n_err = 0;
    int    beats = 0, re_seen = 0, cyc = 0;
    int    beat_cyc[$];
    beat_t exp_q[$];
    bit    rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FIFO model: DEPTH-1 usable entries, registered read data.
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    wp, rp;
    logic [4:0]    fcnt;
    logic [DW-1:0] wdata;
    assign bus.fifo_full  = (fcnt == 5'(DEPTH - 1));
    assign bus.fifo_empty = (fcnt == 5'd0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            wp <= '0; rp <= '0; fcnt <= '0; bus.fifo_dout <= '0;
        end else begin
            if (bus.fifo_we && !bus.fifo_full) begin
                mem[wp] <= wdata;
                wp      <= wp + 4'd1;
            end
            if (bus.fifo_re && !bus.fifo_empty) begin
                bus.fifo_dout <= mem[rp];
                rp            <= rp + 4'd1;
            end
            fcnt <= fcnt + 5'(bus.fifo_we && !bus.fifo_full) - 5'(bus.fifo_re && !bus.fifo_empty);
        end
    end

    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop, stall stability, no read of an empty FIFO.
    logic          prev_stall = 1'b0, prev_last;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.m_tvalid, 1);
                chk("hold_data", bus.m_tdata, prev_data);
                chk("hold_last", bus.m_tlast, prev_last);
            end
            if (bus.fifo_re) begin
                re_seen++;
                chk("re_while_empty", bus.fifo_empty, 0);
            end
            if (bus.m_tvalid && bus.m_tready) begin
                beats++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.m_tdata, e.data);
                    chk("beat_last", bus.m_tlast, e.last);
                end
            end
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
            prev_last  = bus.m_tlast;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bus.fifo_we = 1'b1;
        wdata       = d;
        tick();
        bus.fifo_we = 1'b0;
    endtask

    task automatic write_pkt(input logic [DW-1:0] base);
        for (int i = 0; i < PKT; i++) write_word(base + DW'(i));
    endtask

    task automatic exp_pkt(input logic [47:0] seq, input logic [DW-1:0] base);
        beat_t b;
        b.last = 1'b0;
        b.data = {16'h6E58, seq};
        exp_q.push_back(b);
        for (int i = 0; i < PKT; i++) begin
            b.last = (i == PKT - 1);
            b.data = base + DW'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, beats >= target, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        int b0;
        bus.enable  = 1'b0;
        bus.fifo_we = 1'b0;
        wdata       = '0;
        do_reset();
        @(negedge clk);
        chk("rst_tvalid", bus.m_tvalid, 0);
        chk("rst_tdata", bus.m_tdata, 0);
        chk("rst_tlast", bus.m_tlast, 0);
        chk("rst_fifo_re", bus.fifo_re, 0);
        chk("rst_pkt_count", bus.pkt_count, 0);
        chk("rst_drop_count", bus.drop_count, 0);
        chk("rst_busy", bus.busy, 0);
        tick();

        // Threshold, start latency and basic packet
        bus.enable = 1'b1;
        exp_pkt(48'd0, 64'd1);
        for (int i = 1; i <= 3; i++) write_word(64'(i));
        repeat (8) tick();
        chk("thr_no_read", re_seen, 0);
        chk("thr_no_beat", beats, 0);
        write_word(64'd4);
        @(negedge clk);
        chk("lat_n0_valid", bus.m_tvalid, 0);
        @(negedge clk);
        chk("lat_n1_valid", bus.m_tvalid, 0);
        chk("lat_n1_busy", bus.busy, 1);
        @(negedge clk);
        chk("lat_n2_hdr_valid", bus.m_tvalid, 1);
        chk("lat_n2_fifo_re", bus.fifo_re, 1);
        for (int i = 0; i < PKT; i++) begin
            @(negedge clk);
            chk("stream_no_bubble", bus.m_tvalid, 1);
        end
        @(negedge clk);
        chk("stream_end_idle", bus.m_tvalid, 0);
        tick();
        wait_drain("basic_drain", 50);
        chk("basic_pkt_count", bus.pkt_count, 1);

        // Back-to-back packets: one idle output cycle between them
        beat_cyc.delete();
        exp_pkt(48'd1, 64'd5);
        exp_pkt(48'd2, 64'd9);
        write_pkt(64'd5);
        write_pkt(64'd9);
        wait_drain("b2b_drain", 100);
        chk("b2b_beats", beat_cyc.size(), 2 * (PKT + 1));
        if (beat_cyc.size() == 2 * (PKT + 1)) begin
            chk("b2b_pkt0_contig", beat_cyc[PKT] - beat_cyc[0], PKT);
            chk("b2b_gap", beat_cyc[PKT + 1] - beat_cyc[PKT], 2);
            chk("b2b_pkt1_contig", beat_cyc[2 * PKT + 1] - beat_cyc[PKT + 1], PKT);
        end
        chk("b2b_pkt_count", bus.pkt_count, 3);

        // Random backpressure over 10 packets, sequence numbers from 0
        do_reset();
        rnd_mode = 1'b1;
        for (int k = 0; k < 10; k++) begin
            int n = 0;
            while (fcnt > 5'(DEPTH - 1 - PKT) && n < 500) begin
                tick();
                n++;
            end
            chk("bp_fifo_room", fcnt <= 5'(DEPTH - 1 - PKT), 1);
            exp_pkt(48'(k), 64'h1000 * 64'(k + 1));
            write_pkt(64'h1000 * 64'(k + 1));
        end
        wait_drain("bp_drain", 2000);
        rnd_mode = 1'b0;
        tick();
        chk("bp_pkt_count", bus.pkt_count, 10);

        // Enable dropped during the payload: packet completes, no second header
        bus.enable = 1'b0;
        exp_pkt(48'd10, 64'h2000);
        write_pkt(64'h2000);
        write_pkt(64'h3000);
        b0 = beats;
        bus.enable = 1'b1;
        wait_beats("en_hdr_seen", b0 + 1, 50);
        bus.enable = 1'b0;
        repeat (30) tick();
        chk("en_beats", beats - b0, PKT + 1);
        chk("en_exp_empty", exp_q.size(), 0);
        chk("en_pkt_count", bus.pkt_count, 11);
        chk("en_busy", bus.busy, 0);
        chk("en_occ_left", dut.occ_q, PKT);

        // Overflow: 20 writes into 15 usable entries
        do_reset();
        for (int i = 1; i <= 20; i++) write_word(64'(i));
        tick();
        chk("ovf_drop_count", bus.drop_count, 5);
        chk("ovf_occ", dut.occ_q, DEPTH - 1);
        exp_pkt(48'd0, 64'd1);
        exp_pkt(48'd1, 64'd5);
        exp_pkt(48'd2, 64'd9);
        bus.enable = 1'b1;
        wait_drain("ovf_drain", 200);
        repeat (5) tick();
        chk("ovf_pkt_count", bus.pkt_count, 3);
        chk("ovf_occ_left", dut.occ_q, 3);
        chk("ovf_no_extra", exp_q.size(), 0);

        // Reset in the middle of a packet
        do_reset();
        exp_pkt(48'd0, 64'h100);
        b0 = beats;
        write_pkt(64'h100);
        wait_beats("mid_beats_seen", b0 + 2, 50);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_tvalid", bus.m_tvalid, 0);
        chk("mid_rst_tlast", bus.m_tlast, 0);
        chk("mid_rst_tdata", bus.m_tdata, 0);
        chk("mid_rst_fifo_re", bus.fifo_re, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_pkt_count", bus.pkt_count, 0);
        tick();
        exp_pkt(48'd0, 64'h200);
        write_pkt(64'h200);
        wait_drain("mid_drain", 100);
        chk("mid_pkt_count", bus.pkt_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
